// File: rtl/dual_ram_be_if.sv
`default_nettype none
// ============================================================================
//  Module      : dual_ram_be_if
//  Description : Write/read port bundle for dual_ram_be. The master drives
//                the write and read requests. The slave (the RAM) returns
//                the read data, the read-valid strobe and init_done.
//  Revision    : 1.0  initial release
// ============================================================================
interface dual_ram_be_if #(
  parameter int DW = 32,
  parameter int AW = 12
) ();
  logic              wen;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic [DW/8-1:0]   w_be;
  logic              ren;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic              init_done;

  modport master (
    output wen, w_addr, w_data, w_be, ren, r_addr,
    input  r_data, r_valid, init_done
  );

  modport slave (
    input  wen, w_addr, w_data, w_be, ren, r_addr,
    output r_data, r_valid, init_done
  );
endinterface
`default_nettype wire

// File: rtl/dual_ram_be.sv
`default_nettype none
// ============================================================================
//  Module      : dual_ram_be
//  Description : Simple-dual-port RAM on a single clock with per-byte write
//                enables and per-byte write-first merge on address collision.
//                Provides a read-valid strobe and out-of-range protection.
//                An optional post-reset sweep zeroes the whole array.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_ram_be #(
  parameter int DW         = 32,
  parameter int AW         = 12,
  parameter int MEM_NUM    = 4096,
  parameter int CLR_ON_RST = 1
) (
  input  logic         clk,
  input  logic         rstn,
  dual_ram_be_if.slave bus
);

  localparam int NB = DW / 8;
  // The array index is only as wide as the word count needs. Addresses are
  // range-checked at full width before this truncation is used.
  localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [AW:0]   c_mem_lim = (AW+1)'(MEM_NUM);
  localparam logic [IW-1:0] c_last    = IW'(MEM_NUM - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_cnt;
  logic          r_init_done;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  logic [DW-1:0] mem [0:MEM_NUM-1];

  logic          w_w_inr;
  logic          w_r_inr;
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_ridx;
  logic          w_wr;
  logic          w_rd;
  logic          w_hit;
  logic          w_clr;
  logic [DW-1:0] w_rd_word;
  logic [DW-1:0] w_merged;

  assign w_w_inr   = ({1'b0, bus.w_addr} < c_mem_lim);
  assign w_r_inr   = ({1'b0, bus.r_addr} < c_mem_lim);
  assign w_widx    = bus.w_addr[IW-1:0];
  assign w_ridx    = bus.r_addr[IW-1:0];
  // Traffic is accepted only once init_done is high. Out-of-range writes
  // are dropped here, so truncation of the index can never alias.
  assign w_wr      = r_init_done && bus.wen && w_w_inr;
  assign w_rd      = r_init_done && bus.ren;
  assign w_hit     = w_wr && w_r_inr && (bus.w_addr == bus.r_addr);
  assign w_clr     = (r_state == ST_CLEAR);
  assign w_rd_word = mem[w_ridx];

  // Write-first per byte: an enabled lane of a colliding write bypasses the
  // array. Disabled lanes show the stored byte.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign w_merged[8*gi +: 8] = (w_hit && bus.w_be[gi]) ? bus.w_data[8*gi +: 8]
                                                         : w_rd_word[8*gi +: 8];
  end

  // State register; reset selects whether a clear sweep runs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: the sweep ends once the last word is written; IDLE is terminal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == c_last) w_state_nxt = ST_IDLE;
      ST_IDLE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep address counter and init_done flag, which tracks the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (w_clr) r_cnt <= r_cnt + IW'(1);
      r_init_done <= (w_state_nxt == ST_IDLE);
    end
  end

  // Array update: the sweep writes zeros, user writes update enabled lanes only.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.w_be[i]) mem[w_widx][8*i +: 8] <= bus.w_data[8*i +: 8];
      end
    end
  end

  // Registered read port: holds r_data when idle; an out-of-range read returns zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_r_inr ? w_merged : '0;
    end
  end

  assign bus.r_data    = r_rdata;
  assign bus.r_valid   = r_rvalid;
  assign bus.init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_dual_ram_be.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_ram_be
//  Description : Self-checking bench for dual_ram_be. Three instances share
//                one stimulus: MEM_NUM=16 and MEM_NUM=12 with the clear
//                sweep, and MEM_NUM=16 without the sweep (init_done only).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_ram_be;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  dual_ram_be_if #(.DW(32), .AW(4)) bus0 ();
  dual_ram_be_if #(.DW(32), .AW(4)) bus1 ();
  dual_ram_be_if #(.DW(32), .AW(4)) bus2 ();

  assign bus1.wen = bus0.wen;  assign bus1.w_addr = bus0.w_addr;
  assign bus1.w_data = bus0.w_data;  assign bus1.w_be = bus0.w_be;
  assign bus1.ren = bus0.ren;  assign bus1.r_addr = bus0.r_addr;
  assign bus2.wen = bus0.wen;  assign bus2.w_addr = bus0.w_addr;
  assign bus2.w_data = bus0.w_data;  assign bus2.w_be = bus0.w_be;
  assign bus2.ren = bus0.ren;  assign bus2.r_addr = bus0.r_addr;

  dual_ram_be #(.DW(32), .AW(4), .MEM_NUM(16), .CLR_ON_RST(1)) u_dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  dual_ram_be #(.DW(32), .AW(4), .MEM_NUM(12), .CLR_ON_RST(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  dual_ram_be #(.DW(32), .AW(4), .MEM_NUM(16), .CLR_ON_RST(0)) u_dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word arrays per instance, sweep cycles left, expected outputs.
  logic [31:0] m    [2][16];
  int          lim  [2] = '{16, 12};
  int          swl  [2];
  logic [31:0] e_rd [2];
  logic        e_rv [2];

  function automatic void model_rst();
    for (int d = 0; d < 2; d++) begin
      swl[d]  = lim[d];
      e_rd[d] = 32'h0;
      e_rv[d] = 1'b0;
      for (int a = 0; a < 16; a++) m[d][a] = 32'h0;
    end
  endfunction

  // Advance one clock; the model applies the write first, then reads the updated word.
  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      for (int d = 0; d < 2; d++) begin
        if (swl[d] > 0) begin
          swl[d]--;
          e_rv[d] = 1'b0;
        end else begin
          if (bus0.wen && int'(bus0.w_addr) < lim[d])
            for (int i = 0; i < 4; i++)
              if (bus0.w_be[i]) m[d][bus0.w_addr][8*i +: 8] = bus0.w_data[8*i +: 8];
          e_rv[d] = bus0.ren;
          if (bus0.ren) e_rd[d] = (int'(bus0.r_addr) < lim[d]) ? m[d][bus0.r_addr] : 32'h0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus0.wen = 1'b0; bus0.w_addr = '0; bus0.w_data = '0; bus0.w_be = '0;
    bus0.ren = 1'b0; bus0.r_addr = '0;
  endtask

  // Counts cycles after release until each init_done rises; flags r_valid during a sweep.
  task automatic wait_init(output int r0, output int r1, output int r2, output bit bad);
    r0 = -1; r1 = -1; r2 = -1; bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus0.init_done && r0 < 0) r0 = c;
      if (bus1.init_done && r1 < 0) r1 = c;
      if (bus2.init_done && r2 < 0) r2 = c;
      if ((!bus0.init_done && bus0.r_valid) || (!bus1.init_done && bus1.r_valid)) bad = 1'b1;
      if (r0 >= 0 && r1 >= 0 && r2 >= 0) break;
    end
  endtask

  task automatic test_reset();
    int r0, r1, r2;
    bit bad;
    idle_inputs();
    rstn = 1'b0;
    model_rst();
    #22;
    checks++;
    if ({bus0.r_data, bus0.r_valid, bus0.init_done, bus1.init_done, bus2.init_done} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state actual=%h/%b/%b/%b/%b required=0", bus0.r_data, bus0.r_valid,
               bus0.init_done, bus1.init_done, bus2.init_done);
    end
    bus0.ren = 1'b1;
    @(negedge clk) rstn = 1'b1;
    wait_init(r0, r1, r2, bad);
    checks++;
    if (r0 !== 16) begin errors++; $display("FAIL sweep_len16 actual=%0d required=16", r0); end
    checks++;
    if (r1 !== 12) begin errors++; $display("FAIL sweep_len12 actual=%0d required=12", r1); end
    checks++;
    if (r2 !== 1) begin errors++; $display("FAIL no_sweep_init actual=%0d required=1", r2); end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL valid_in_sweep actual=%b required=0", bad); end
    for (int a = 0; a < 16; a++) begin
      bus0.r_addr = 4'(a);
      tick();
      checks++;
      if (bus0.r_data !== 32'h0 || bus0.r_valid !== 1'b1 || bus1.r_data !== 32'h0 || bus1.r_valid !== 1'b1) begin
        errors++;
        $display("FAIL clear_read a=%0d actual=%h/%b %h/%b required=0/1", a, bus0.r_data, bus0.r_valid,
                 bus1.r_data, bus1.r_valid);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_byte_enable();
    bus0.wen = 1'b1; bus0.w_addr = 4'd3; bus0.w_data = 32'hAABBCCDD; bus0.w_be = 4'b1111;
    tick();
    bus0.w_data = 32'h11223344; bus0.w_be = 4'b0101;
    tick();
    bus0.wen = 1'b0; bus0.ren = 1'b1; bus0.r_addr = 4'd3;
    tick();
    checks++;
    if (bus0.r_data !== 32'hAA22CC44 || bus0.r_valid !== 1'b1) begin
      errors++; $display("FAIL byte_en0 actual=%h/%b required=aa22cc44/1", bus0.r_data, bus0.r_valid);
    end
    checks++;
    if (bus1.r_data !== 32'hAA22CC44) begin
      errors++; $display("FAIL byte_en1 actual=%h required=aa22cc44", bus1.r_data);
    end
    bus0.ren = 1'b0; bus0.wen = 1'b1; bus0.w_be = 4'b0000; bus0.w_data = 32'hDEADBEEF;
    tick();
    bus0.wen = 1'b0; bus0.ren = 1'b1;
    tick();
    checks++;
    if (bus0.r_data !== 32'hAA22CC44) begin
      errors++; $display("FAIL be_zero actual=%h required=aa22cc44", bus0.r_data);
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    bus0.wen = 1'b1; bus0.w_addr = 4'd5; bus0.w_data = 32'h01020304; bus0.w_be = 4'b1111;
    tick();
    bus0.w_data = 32'hFFEEDDCC; bus0.w_be = 4'b1100; bus0.ren = 1'b1; bus0.r_addr = 4'd5;
    tick();
    checks++;
    if (bus0.r_data !== 32'hFFEE0304 || bus0.r_valid !== 1'b1) begin
      errors++; $display("FAIL collide_rd actual=%h/%b required=ffee0304/1", bus0.r_data, bus0.r_valid);
    end
    bus0.wen = 1'b0;
    tick();
    checks++;
    if (bus0.r_data !== 32'hFFEE0304 || bus1.r_data !== 32'hFFEE0304) begin
      errors++; $display("FAIL collide_mem actual=%h %h required=ffee0304", bus0.r_data, bus1.r_data);
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    bus0.wen = 1'b1; bus0.w_addr = 4'd2; bus0.w_data = 32'h0000BEEF; bus0.w_be = 4'b1111;
    tick();
    bus0.wen = 1'b0; bus0.ren = 1'b1; bus0.r_addr = 4'd2;
    tick();
    checks++;
    if (bus0.r_data !== 32'h0000BEEF || bus0.r_valid !== 1'b1) begin
      errors++; $display("FAIL hold_first actual=%h/%b required=0000beef/1", bus0.r_data, bus0.r_valid);
    end
    bus0.ren = 1'b0; bus0.wen = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus0.w_addr = 4'(7 + k); bus0.w_data = $urandom;
      tick();
      checks++;
      if (bus0.r_data !== 32'h0000BEEF || bus0.r_valid !== 1'b0) begin
        errors++; $display("FAIL hold_%0d actual=%h/%b required=0000beef/0", k, bus0.r_data, bus0.r_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    bus0.wen = 1'b1; bus0.w_addr = 4'd13; bus0.w_data = 32'h5A5A5A5A; bus0.w_be = 4'b1111;
    tick();
    bus0.wen = 1'b0; bus0.ren = 1'b1; bus0.r_addr = 4'd13;
    tick();
    checks++;
    if (bus1.r_data !== 32'h0 || bus1.r_valid !== 1'b1) begin
      errors++; $display("FAIL oor_read actual=%h/%b required=0/1", bus1.r_data, bus1.r_valid);
    end
    checks++;
    if (bus0.r_data !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL inr_read13 actual=%h required=5a5a5a5a", bus0.r_data);
    end
    bus0.r_addr = 4'd1;
    tick();
    checks++;
    if (bus1.r_data !== 32'h0 || bus1.r_valid !== 1'b1) begin
      errors++; $display("FAIL oor_alias actual=%h/%b required=0/1", bus1.r_data, bus1.r_valid);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bus0.wen    = 1'($urandom);
      bus0.w_addr = 4'($urandom_range(0, 15));
      bus0.w_data = $urandom;
      bus0.w_be   = 4'($urandom);
      bus0.ren    = ($urandom_range(0, 3) != 0);
      bus0.r_addr = ($urandom_range(0, 3) == 0) ? bus0.w_addr : 4'($urandom_range(0, 15));
      tick();
      for (int d = 0; d < 2; d++) begin
        logic [31:0] ad;
        logic        av;
        ad = (d == 0) ? bus0.r_data : bus1.r_data;
        av = (d == 0) ? bus0.r_valid : bus1.r_valid;
        checks++;
        if (ad !== e_rd[d] || av !== e_rv[d]) begin
          errors++;
          $display("FAIL random d=%0d n=%0d actual=%h/%b required=%h/%b", d, n, ad, av, e_rd[d], e_rv[d]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int r0, r1, r2;
    bit bad;
    rstn = 1'b0; model_rst();
    @(negedge clk) rstn = 1'b1;
    repeat (7) tick();
    #2 rstn = 1'b0; model_rst();
    #1;
    checks++;
    if ({bus0.r_valid, bus0.init_done, bus1.init_done, bus2.init_done} !== 4'h0) begin
      errors++; $display("FAIL rst_sweep actual=%b%b%b%b required=0000", bus0.r_valid, bus0.init_done,
                         bus1.init_done, bus2.init_done);
    end
    @(negedge clk) rstn = 1'b1;
    wait_init(r0, r1, r2, bad);
    checks++;
    if (r0 !== 16 || r1 !== 12 || bad !== 1'b0) begin
      errors++; $display("FAIL resweep actual=%0d/%0d/%b required=16/12/0", r0, r1, bad);
    end
    bus0.wen = 1'b1; bus0.w_addr = 4'd4; bus0.w_data = 32'hCAFEF00D; bus0.w_be = 4'b1111;
    tick();
    bus0.wen = 1'b0; bus0.ren = 1'b1; bus0.r_addr = 4'd4;
    tick();
    checks++;
    if (bus0.r_data !== 32'hCAFEF00D || bus0.r_valid !== 1'b1) begin
      errors++; $display("FAIL pre_rst_read actual=%h/%b required=cafef00d/1", bus0.r_data, bus0.r_valid);
    end
    #2 rstn = 1'b0; model_rst();
    #1;
    checks++;
    if (bus0.r_data !== 32'h0 || bus0.r_valid !== 1'b0 || bus0.init_done !== 1'b0) begin
      errors++; $display("FAIL rst_traffic actual=%h/%b/%b required=0/0/0", bus0.r_data, bus0.r_valid,
                         bus0.init_done);
    end
    @(negedge clk) rstn = 1'b1;
    tick();
    checks++;
    if (bus0.r_valid !== 1'b0) begin
      errors++; $display("FAIL inflight_valid actual=%b required=0", bus0.r_valid);
    end
    wait_init(r0, r1, r2, bad);
    checks++;
    if (r0 !== 15 || r1 !== 11) begin
      errors++; $display("FAIL resweep2 actual=%0d/%0d required=15/11", r0, r1);
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();
    test_reset();
    test_byte_enable();
    test_collision();
    test_hold();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
